uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, meaning data bits per received word.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the receive buffer depth in words (power of two, >=2).
REQ-003 The block SHALL have parameter DIV_WIDTH, default 11, meaning the width of the baud divisor.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-006 The block SHALL have port en, input, 1, meaning the receiver enable.
REQ-007 The block SHALL have port divisor, input, DIV_WIDTH, meaning clk cycles per s_tick.
REQ-008 The block SHALL have port s_tick, output, 1, meaning the oversampling tick to the receiver.
REQ-009 The block SHALL have ports rx_done (input, 1) and rx_dout (input, DBIT), meaning the receiver's word-complete pulse and its data.
REQ-010 The block SHALL have ports rd_valid (output, 1), rd_ready (input, 1) and rd_data (output, DBIT), meaning the consumer read handshake.
REQ-011 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH+1), meaning the number of words held.
REQ-012 The block SHALL have ports flush (input, 1), overrun (output, 1), clr_overrun (input, 1) and ovr_cnt (output, 8).

Function
REQ-013 The FSM SHALL have states DISABLED, RUN and DRAIN.
REQ-014 The FSM SHALL move DISABLED->RUN when en=1, RUN->DRAIN when en=0, DRAIN->RUN when en=1, and DRAIN->DISABLED when en=0 and fifo_count==0.
REQ-015 In RUN, the divider counter SHALL count 0..max(divisor,1)-1 and wrap; s_tick SHALL be registered and high for exactly one cycle per wrap (divisor 0 or 1 gives s_tick every cycle).
REQ-016 In DISABLED and DRAIN, the divider counter SHALL be held at 0 and s_tick SHALL be 0; the first s_tick after entering RUN comes max(divisor,1) cycles later.
REQ-017 A divisor change SHALL take effect at the next wrap, or immediately if the counter is already >= the new divisor-1 (tick and wrap).
REQ-018 An rx_done=1 cycle in RUN or DRAIN SHALL push rx_dout; rx_done in DISABLED SHALL be ignored.
REQ-019 rd_valid SHALL equal (fifo_count!=0); rd_data SHALL present the oldest word (show-ahead) and is don't-care when rd_valid=0.
REQ-020 A pop SHALL occur when rd_valid && rd_ready.
REQ-021 A simultaneous push and pop SHALL leave fifo_count unchanged, including when full; in that case the push is accepted and no overrun occurs.
REQ-022 A push when full without a pop SHALL drop the word and set overrun (sticky); it SHALL NOT modify stored data.
REQ-023 clr_overrun SHALL clear overrun next cycle; a set in the same cycle wins.
REQ-024 flush SHALL empty the FIFO next cycle (pointers and count to 0); pushes and pops in the same cycle are discarded, and overrun is unaffected.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-026 On rst_n=0, asynchronously: state=DISABLED, divider=0, s_tick=0, pointers=0, fifo_count=0 (rd_valid=0), overrun=0, ovr_cnt=0; FIFO storage need not be reset.
REQ-027 A reset mid-operation SHALL discard all buffered words; no s_tick is produced until en is sampled 1 after reset release.

Configuration
REQ-028 With UART_RX_CTRL_OVR_CNT_EN defined, ovr_cnt SHALL increment by 1 per dropped word, saturate at 255, and clear on clr_overrun.
REQ-029 Without UART_RX_CTRL_OVR_CNT_EN, ovr_cnt SHALL be constant 0, and all other behaviour is identical.

Verification
REQ-030 Bench: en=1, divisor=4 -> s_tick pulses every 4th cycle, first pulse 4 cycles after RUN entry; divisor=0 -> every cycle.
REQ-031 Bench: push 0xA5, 0x3C with rd_ready=0 -> fifo_count=2, rd_data=0xA5; rd_ready=1 -> 0xA5 then 0x3C, then rd_valid=0.
REQ-032 Bench: fill 8 words, push 0x77 without pop -> overrun=1, count=8, 0x77 absent, ovr_cnt=1 (macro defined) or 0 (undefined); with a same-cycle pop instead -> overrun=0 and 0x77 is read last.
REQ-033 Bench: 3 words buffered, en->0 -> DRAIN, s_tick=0; after 3 pops -> DISABLED; rx_done in DISABLED -> count stays 0.
REQ-034 Bench: flush with 5 words plus a simultaneous push -> count=0 next cycle, overrun unchanged; clr_overrun and overflow in the same cycle -> overrun=1.
REQ-035 Bench: assert rst_n=0 mid-stream with 4 words buffered -> all outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-side handshake bundle: word-complete strobe/data in, show-ahead read port out.
// master = uart_rx_ctrl, slave = receiver/consumer side.
interface uart_rx_ctrl_if #(
   parameter int DBIT = 8
);
   logic            rx_done;
   logic [DBIT-1:0] rx_dout;
   logic            rd_valid;
   logic            rd_ready;
   logic [DBIT-1:0] rd_data;

   modport master (input rx_done, rx_dout, rd_ready, output rd_valid, rd_data);
   modport slave  (output rx_done, rx_dout, rd_ready, input rd_valid, rd_data);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud tick divider, RUN/DRAIN/DISABLED FSM and show-ahead receive FIFO.
// Optional saturating drop counter on ovr_cnt when UART_RX_CTRL_OVR_CNT_EN is defined.
module uart_rx_ctrl #(
   parameter int DBIT       = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_WIDTH  = 11
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              en,
   input  logic [DIV_WIDTH-1:0]              divisor,
   output logic                              s_tick,
   uart_rx_ctrl_if.master                    bus,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   input  logic                              flush,
   output logic                              overrun,
   input  logic                              clr_overrun,
   output logic [7:0]                        ovr_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [1:0] DISABLED = 2'd0;
   localparam logic [1:0] RUN      = 2'd1;
   localparam logic [1:0] DRAIN    = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d, div_max;
   logic                 tick_q, tick_d;
   logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 ovr_q, ovr_d;
   logic [7:0]           ovr_cnt_q, ovr_cnt_d;
   logic [DBIT-1:0]      mem [FIFO_DEPTH];

   logic push_req, pop, full, push, drop;

   always_comb begin
      full     = (count_q == CW'(FIFO_DEPTH));
      pop      = (count_q != '0) && bus.rd_ready;
      push_req = bus.rx_done && (state_q != DISABLED);
      push     = push_req && (!full || pop) && !flush;
      drop     = push_req && full && !pop && !flush;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DISABLED: if (en) state_d = RUN;
         RUN:      if (!en) state_d = DRAIN;
         DRAIN:    if (en) state_d = RUN;
                   else if (count_q == '0) state_d = DISABLED;
         default:  state_d = DISABLED;
      endcase
   end

   // Gating on en keeps s_tick low on the very first DRAIN cycle as well.
   always_comb begin
      div_max   = (divisor == '0) ? '0 : divisor - 1'b1;
      div_cnt_d = '0;
      tick_d    = 1'b0;
      if (state_q == RUN && en) begin
         if (div_cnt_q >= div_max) begin
            tick_d = 1'b1;
         end else begin
            div_cnt_d = div_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + 1'b1;
         if (pop)  rptr_d = rptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   always_comb begin
      ovr_d = ovr_q;
      if (drop) ovr_d = 1'b1;
      else if (clr_overrun) ovr_d = 1'b0;
`ifdef UART_RX_CTRL_OVR_CNT_EN
      ovr_cnt_d = ovr_cnt_q;
      if (drop) begin
         if (clr_overrun)             ovr_cnt_d = 8'd1;
         else if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 1'b1;
      end else if (clr_overrun) begin
         ovr_cnt_d = '0;
      end
`else
      ovr_cnt_d = '0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= DISABLED;
         div_cnt_q <= '0;
         tick_q    <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         ovr_q     <= 1'b0;
         ovr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         tick_q    <= tick_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         ovr_q     <= ovr_d;
         ovr_cnt_q <= ovr_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr_q] <= bus.rx_dout;
   end

   assign s_tick       = tick_q;
   assign fifo_count   = count_q;
   assign bus.rd_valid = (count_q != '0);
   assign bus.rd_data  = mem[rptr_q];
   assign overrun      = ovr_q;
   assign ovr_cnt      = ovr_cnt_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: FIFO table vectors plus hand sequences for divider, DRAIN and async reset.
module tb_uart_rx_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [10:0] divisor;
   logic        s_tick;
   logic [3:0]  fifo_count;
   logic        flush;
   logic        overrun;
   logic        clr_overrun;
   logic [7:0]  ovr_cnt;

   int tests = 0;
   int fails = 0;

`ifdef UART_RX_CTRL_OVR_CNT_EN
   localparam bit OCE = 1'b1;
`else
   localparam bit OCE = 1'b0;
`endif

   uart_rx_ctrl_if #(.DBIT(8)) bus ();

   uart_rx_ctrl #(.DBIT(8), .FIFO_DEPTH(8), .DIV_WIDTH(11)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .divisor     (divisor),
      .s_tick      (s_tick),
      .bus         (bus),
      .fifo_count  (fifo_count),
      .flush       (flush),
      .overrun     (overrun),
      .clr_overrun (clr_overrun),
      .ovr_cnt     (ovr_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         rxd;
      logic [7:0] din;
      bit         rdy;
      bit         fl;
      bit         clr;
      int         cnt;
      bit         vld;
      logic [7:0] dat;
      bit         ovr;
      int         oc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit rxd, logic [7:0] din, bit rdy, bit fl, bit clr,
                               int cnt, bit vld, logic [7:0] dat, bit ovr, int oc);
      vec_t v;
      v.rxd = rxd; v.din = din; v.rdy = rdy; v.fl = fl; v.clr = clr;
      v.cnt = cnt; v.vld = vld; v.dat = dat; v.ovr = ovr; v.oc = oc;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " count"},    int'(fifo_count),   0);
      chk({tag, " rd_valid"}, int'(bus.rd_valid), 0);
      chk({tag, " overrun"},  int'(overrun),      0);
      chk({tag, " ovr_cnt"},  int'(ovr_cnt),      0);
      chk({tag, " s_tick"},   int'(s_tick),       0);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; divisor = 11'd4; flush = 1'b0; clr_overrun = 1'b0;
      bus.rx_done = 1'b0; bus.rx_dout = '0; bus.rd_ready = 1'b0;

      // ---- reset state
      step(); step();
      chk_reset_vals("reset");
      rst_n = 1'b1;
      step();

      // ---- divider: divisor 4, first tick 4 cycles after RUN entry
      en = 1'b1; divisor = 11'd4;
      for (int k = 1; k <= 12; k++) begin
         step();
         chk($sformatf("tick div4 k=%0d", k), int'(s_tick), int'(k >= 5 && ((k - 5) % 4) == 0));
      end
      divisor = 11'd0;
      for (int k = 13; k <= 18; k++) begin
         step();
         chk($sformatf("tick div0 k=%0d", k), int'(s_tick), 1);
      end

      // ---- FIFO table
      tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 1, 8'hA5, 0, 0));
      tbl.push_back(mk(1, 8'h3C, 0, 0, 0, 2, 1, 8'hA5, 0, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 1, 8'h3C, 0, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0));
      for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 8'h11 + 8'(i), 0, 0, 0, i + 1, 1, 8'h11, 0, 0));
      tbl.push_back(mk(1, 8'h77, 0, 0, 0, 8, 1, 8'h11, 1, 1));
      for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 8'h00, 1, 0, 0, 7 - i, i < 7, 8'h12 + 8'(i), 1, 1));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0));
      for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 8'h21 + 8'(i), 0, 0, 0, i + 1, 1, 8'h21, 0, 0));
      tbl.push_back(mk(1, 8'h77, 1, 0, 0, 8, 1, 8'h22, 0, 0));
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(0, 8'h00, 1, 0, 0, 7 - i, i < 7, (i < 6) ? 8'h23 + 8'(i) : 8'h77, 0, 0));
      for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 8'h31 + 8'(i), 0, 0, 0, i + 1, 1, 8'h31, 0, 0));
      tbl.push_back(mk(1, 8'h99, 0, 0, 1, 8, 1, 8'h31, 1, 1));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 8'h00, 1, 0, 0, 7 - i, 1, 8'h32 + 8'(i), 1, 1));
      tbl.push_back(mk(1, 8'h55, 1, 1, 0, 0, 0, 8'h00, 1, 1));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0));

      foreach (tbl[n]) begin
         bus.rx_done = tbl[n].rxd; bus.rx_dout = tbl[n].din; bus.rd_ready = tbl[n].rdy;
         flush = tbl[n].fl; clr_overrun = tbl[n].clr;
         step();
         chk($sformatf("vec%0d count", n),    int'(fifo_count),   tbl[n].cnt);
         chk($sformatf("vec%0d rd_valid", n), int'(bus.rd_valid), int'(tbl[n].vld));
         if (tbl[n].vld) chk($sformatf("vec%0d rd_data", n), int'(bus.rd_data), int'(tbl[n].dat));
         chk($sformatf("vec%0d overrun", n),  int'(overrun),      int'(tbl[n].ovr));
         chk($sformatf("vec%0d ovr_cnt", n),  int'(ovr_cnt),      OCE ? tbl[n].oc : 0);
      end
      bus.rx_done = 1'b0; bus.rd_ready = 1'b0; flush = 1'b0; clr_overrun = 1'b0;

      // ---- DRAIN: 3 words buffered, en drops, ticks stop, drain to DISABLED
      divisor = 11'd1;
      for (int i = 0; i < 3; i++) begin
         bus.rx_done = 1'b1; bus.rx_dout = 8'h41 + 8'(i);
         step();
      end
      bus.rx_done = 1'b0;
      chk("pre-drain count", int'(fifo_count), 3);
      chk("pre-drain s_tick", int'(s_tick), 1);
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("drain s_tick %0d", i), int'(s_tick), 0);
         chk($sformatf("drain hold count %0d", i), int'(fifo_count), 3);
      end
      bus.rd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("drain pop count %0d", i), int'(fifo_count), 2 - i);
      end
      bus.rd_ready = 1'b0;
      step();
      bus.rx_done = 1'b1; bus.rx_dout = 8'h66;
      step();
      bus.rx_done = 1'b0;
      chk("disabled push ignored count", int'(fifo_count), 0);
      chk("disabled push ignored valid", int'(bus.rd_valid), 0);
      en = 1'b1;
      step();
      chk("rerun entry s_tick", int'(s_tick), 0);
      step();
      chk("rerun first tick", int'(s_tick), 1);

      // ---- async reset mid-stream with 4 words and overrun set
      for (int i = 0; i < 9; i++) begin
         bus.rx_done = 1'b1; bus.rx_dout = 8'hE0 + 8'(i);
         step();
      end
      bus.rx_done = 1'b0; bus.rd_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      bus.rd_ready = 1'b0;
      chk("pre-reset count", int'(fifo_count), 4);
      chk("pre-reset overrun", int'(overrun), 1);
      chk("pre-reset ovr_cnt", int'(ovr_cnt), OCE ? 1 : 0);
      chk("pre-reset s_tick", int'(s_tick), 1);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("async reset");
      en = 1'b0;
      step(); step();
      #3 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("post-reset idle s_tick %0d", i), int'(s_tick), 0);
         chk($sformatf("post-reset idle count %0d", i), int'(fifo_count), 0);
      end
      en = 1'b1;
      step();
      chk("post-reset entry s_tick", int'(s_tick), 0);
      step();
      chk("post-reset first tick", int'(s_tick), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
